// File: rtl/mmcm_reset_sequencer_if.sv
// Signal bundle between the MMCM reset sequencer and the MMCM / clock-domain consumers.
// LOCK_LOSS_COUNT_EN adds the lock_loss_cnt observation bus.
interface mmcm_reset_sequencer_if;
    logic       locked_async;
    logic       relock_req;
    logic       mmcm_rst;
    logic       domain_rst_n;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] lock_loss_cnt;

    modport master (
        input  locked_async,
        input  relock_req,
        output mmcm_rst,
        output domain_rst_n,
        output ready,
        output fail,
        output retry_cnt,
        output lock_loss_cnt
    );

    modport slave (
        output locked_async,
        output relock_req,
        input  mmcm_rst,
        input  domain_rst_n,
        input  ready,
        input  fail,
        input  retry_cnt,
        input  lock_loss_cnt
    );
`else
    modport master (
        input  locked_async,
        input  relock_req,
        output mmcm_rst,
        output domain_rst_n,
        output ready,
        output fail,
        output retry_cnt
    );

    modport slave (
        output locked_async,
        output relock_req,
        input  mmcm_rst,
        input  domain_rst_n,
        input  ready,
        input  fail,
        input  retry_cnt
    );
`endif
endinterface

// File: rtl/mmcm_reset_sequencer.sv
// MMCM reset/lock sequencer: pulses RESET, waits for a stable lock, releases the domain reset.
// Optional macro LOCK_LOSS_COUNT_EN adds a saturating count of lock losses seen in RUN.
//
// state     | meaning
// ST_RST    | mmcm_rst held high for RST_CYCLES
// ST_WAIT   | mmcm_rst low, waiting for synchronized lock (bounded by LOCK_TIMEOUT)
// ST_STABLE | lock must hold STABLE_CYCLES consecutive cycles
// ST_RUN    | domain released, ready high
// ST_FAIL   | retries exhausted, mmcm_rst held, waiting for reset or relock_req
module mmcm_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRY     = 4,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    mmcm_reset_sequencer_if.master bus
);

    localparam logic [2:0] ST_RST    = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_STABLE = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_FAIL   = 3'd4;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [3:0]       RETRY_LAST   = 4'(MAX_RETRY - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRY);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       retry_q, retry_d;
    logic             lk_meta_q, lk_meta_d;
    logic             lk_s_q, lk_s_d;
    logic             mmcm_rst_q, mmcm_rst_d;
    logic             domain_rst_n_q, domain_rst_n_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;
    logic             attempt_fail;
    logic             run_hold;

    assign lk_meta_d = bus.locked_async;
    assign lk_s_d    = lk_meta_q;

    // Saturating increment keeps the counter from wrapping inside a state.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        retry_d      = retry_q;
        attempt_fail = 1'b0;

        case (state_q)
            ST_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT: begin
                if (lk_s_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    attempt_fail = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_STABLE: begin
                if (!lk_s_q) begin
                    attempt_fail = 1'b1;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RUN: begin
                // Lock loss after release re-sequences without consuming a retry.
                if (!lk_s_q) begin
                    state_d = ST_RST;
                    cnt_d   = '0;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_RST;
                cnt_d   = '0;
            end
        endcase

        if (attempt_fail) begin
            cnt_d = '0;
            if (retry_q < RETRY_LAST) begin
                retry_d = retry_q + 4'd1;
                state_d = ST_RST;
            end else begin
                retry_d = RETRY_MAX;
                state_d = ST_FAIL;
            end
        end

        if (bus.relock_req) begin
            state_d = ST_RST;
            cnt_d   = '0;
            retry_d = '0;
        end
    end

    // Domain reset and ready open one edge after entering RUN and close on the edge RUN is left.
    assign run_hold       = (state_q == ST_RUN) && (state_d == ST_RUN);
    assign domain_rst_n_d = run_hold;
    assign ready_d        = run_hold;
    assign mmcm_rst_d     = (state_d == ST_RST) || (state_d == ST_FAIL);
    assign fail_d         = (state_d == ST_FAIL);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_RST;
            cnt_q          <= '0;
            retry_q        <= '0;
            lk_meta_q      <= 1'b0;
            lk_s_q         <= 1'b0;
            mmcm_rst_q     <= 1'b1;
            domain_rst_n_q <= 1'b0;
            ready_q        <= 1'b0;
            fail_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            retry_q        <= retry_d;
            lk_meta_q      <= lk_meta_d;
            lk_s_q         <= lk_s_d;
            mmcm_rst_q     <= mmcm_rst_d;
            domain_rst_n_q <= domain_rst_n_d;
            ready_q        <= ready_d;
            fail_q         <= fail_d;
        end
    end

    assign bus.mmcm_rst     = mmcm_rst_q;
    assign bus.domain_rst_n = domain_rst_n_q;
    assign bus.ready        = ready_q;
    assign bus.fail         = fail_q;
    assign bus.retry_cnt    = retry_q;

`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] lock_loss_cnt_q, lock_loss_cnt_d;
    logic       lock_lost;

    // relock_req pre-empts the RUN exit, so that cycle is not a lock loss.
    assign lock_lost = (state_q == ST_RUN) && !lk_s_q && !bus.relock_req;

    always_comb begin
        lock_loss_cnt_d = lock_loss_cnt_q;
        if (lock_lost && (lock_loss_cnt_q != 8'hFF)) begin
            lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lock_loss_cnt_q <= 8'd0;
        end else begin
            lock_loss_cnt_q <= lock_loss_cnt_d;
        end
    end

    assign bus.lock_loss_cnt = lock_loss_cnt_q;
`endif

endmodule

// File: doc/mmcm_reset_sequencer.md
Name: mmcm_reset_sequencer

Overview:
- Sequences the MMCM reset/lock handshake from the free-running input-clock domain `clk`, which is the MMCM `CLK_IN1` source.
- Drives MMCM `RESET`, waits for `LOCKED`, and requires lock to hold for a stability window before releasing the downstream active-low domain reset.
- On lock loss or lock timeout, re-runs the reset with bounded retries; declares failure after the retry limit.
- Sits between board reset and every consumer of the MMCM output clock.

Parameters:
- RST_CYCLES, 16: cycles `mmcm_rst` is held high per attempt (min 3).
- LOCK_TIMEOUT, 4096: max cycles in WAIT_LOCK before the attempt is abandoned.
- STABLE_CYCLES, 256: consecutive synchronized-locked cycles required before release.
- MAX_RETRY, 4: failed attempts allowed before FAIL (1..15).
- CNT_W, 16: width of the internal cycle counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- clk, input, 1: free-running input clock; the MMCM reference.
- reset, input, 1: synchronous, active-low block reset.
- locked_async, input, 1: MMCM `LOCKED`, asynchronous to `clk`.
- relock_req, input, 1: single-cycle pulse requesting a full re-sequence.
- mmcm_rst, output, 1: MMCM `RESET`, active-high.
- domain_rst_n, output, 1: active-low reset for MMCM-clocked logic.
- ready, output, 1: high only in RUN.
- fail, output, 1: sticky failure flag.
- retry_cnt, output, 4: failed attempts in the current sequence.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-low on `reset`.
- Lock synchronizer: `locked_async` passes through a 2-FF synchronizer to `lk_s`. All decisions use `lk_s`. Synchronizer flops clear to 0 on reset.
- Reset values (`reset`=0 sampled at a `clk` edge):
  - state = RST, counter = 0, retry_cnt = 0.
  - mmcm_rst = 1, domain_rst_n = 0, ready = 0, fail = 0.
- All outputs are registered.
- RST:
  - mmcm_rst = 1, domain_rst_n = 0.
  - Counter counts 0..RST_CYCLES-1, then clears; next state WAIT_LOCK.
  - mmcm_rst is high for exactly RST_CYCLES cycles per attempt.
- WAIT_LOCK:
  - mmcm_rst = 0, counter increments.
  - lk_s = 1: go to STABLE, counter clears.
  - Counter reaches LOCK_TIMEOUT-1 with lk_s = 0: attempt failed (see retry rule).
- STABLE:
  - lk_s = 1: counter increments; at STABLE_CYCLES-1 go to RUN.
  - lk_s = 0 at any cycle: attempt failed (glitch rejection).
- RUN:
  - domain_rst_n = 1, ready = 1, retry_cnt cleared to 0 on entry.
  - lk_s = 0: domain_rst_n = 0 and ready = 0 on the next edge; go to RST. This does not count as a retry.
- Retry rule on a failed attempt:
  - retry_cnt < MAX_RETRY-1: retry_cnt += 1, go to RST.
  - Otherwise: retry_cnt = MAX_RETRY, go to FAIL.
- FAIL:
  - mmcm_rst = 1, domain_rst_n = 0, fail = 1, ready = 0.
  - Stays in FAIL until `reset` or `relock_req`.
- relock_req:
  - Honoured in any state.
  - Next state RST, counter = 0, retry_cnt = 0, fail = 0, domain_rst_n = 0.
  - Takes priority over every same-cycle transition, including a timeout or stable-complete in that cycle.
  - If asserted in the same cycle as `reset`=0, `reset` wins; the end state is identical.
- domain_rst_n:
  - Deasserts exactly 1 edge after entering RUN, i.e. registered from state == RUN.
  - Always asserts on the same edge the FSM leaves RUN.
- Latency: minimum time from reset release to ready = RST_CYCLES + 2 (sync) + STABLE_CYCLES + 1 cycles.
- Counter: saturating; it never wraps inside a state.

Optional Feature:
- Macro: LOCK_LOSS_COUNT_EN.
- Defined:
  - Adds output `lock_loss_cnt[7:0]`, counting RUN to RST transitions caused by lk_s = 0.
  - The count saturates at 255.
  - Cleared only by `reset` (not by relock_req).
  - Reset value 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Nominal lock:
  - Stimulus: RST_CYCLES=16, STABLE_CYCLES=256; locked_async rises 100 cycles after mmcm_rst falls.
  - Required: mmcm_rst high exactly 16 cycles; ready and domain_rst_n rise 100+2+256+1 cycles after mmcm_rst falls; retry_cnt = 0.
- Lock glitch in STABLE:
  - Stimulus: locked drops for 5 cycles at STABLE count 100, then recovers.
  - Required: return to RST; retry_cnt = 1; second attempt reaches RUN with retry_cnt cleared to 0.
- Timeout to FAIL:
  - Stimulus: locked_async held 0, MAX_RETRY=4, LOCK_TIMEOUT=64.
  - Required: exactly 4 mmcm_rst pulses of 16 cycles each; then fail = 1, retry_cnt = 4, mmcm_rst held 1.
- Lock loss in RUN:
  - Stimulus: locked drops for 1 cycle while in RUN.
  - Required: domain_rst_n = 0 and ready = 0 by 3 edges after the drop; full resequence follows; retry_cnt stays 0; with LOCK_LOSS_COUNT_EN, lock_loss_cnt = 1.
- relock_req priority:
  - Stimulus: relock_req pulsed in FAIL, and separately on the same cycle STABLE completes.
  - Required: both cases enter RST; fail = 0; ready stays 0.
- Reset mid-operation:
  - Stimulus: reset=0 for 1 cycle during WAIT_LOCK.
  - Required: next cycle mmcm_rst = 1, retry_cnt = 0, counter = 0, lock_loss_cnt = 0.
